// File: rtl/interrupt_ack_sequencer_if.sv
// interrupt_ack_sequencer_if: PIC-side pins and core-side result handshake for the
// interrupt acknowledge sequencer. The "master" modport is the sequencer's view.
// The "slave" modport is the view of the PIC model plus the consumer.
interface interrupt_ack_sequencer_if;
    logic        INT;
    logic        interruptEnable;
    logic        mode8086;
    logic [7:0]  dataBus;
    logic        vectorAck;
    logic        INTA_n;
    logic        vectorValid;
    logic [7:0]  vectorData;
    logic [15:0] callAddress;
    logic        busy;
    logic        protocolError;

    modport master (
        input  INT, interruptEnable, mode8086, dataBus, vectorAck,
        output INTA_n, vectorValid, vectorData, callAddress, busy, protocolError
    );

    modport slave (
        output INT, interruptEnable, mode8086, dataBus, vectorAck,
        input  INTA_n, vectorValid, vectorData, callAddress, busy, protocolError
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: watches the PIC's INT line and runs the INTA_n pulse train.
// It supports the two-pulse 8086 form and the three-pulse 8080/85 form.
// It captures the bytes the PIC drives at the end of each pulse.
// The result is presented through a valid/ack handshake.
// Optional feature macro: OPCODE_CHECK_EN. When defined, an 8080 opcode byte other
// than CALL (8'hCD) sets a sticky protocolError flag. When undefined, the flag is 0.
module interrupt_ack_sequencer #(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    interrupt_ack_sequencer_if.master bus
);

    localparam int unsigned CntMax = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                     INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] LowLast = CntW'(INTA_LOW_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(INTA_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPulseLow,
        StGap,
        StPresent
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cycle;
    logic [1:0]      r_pulse;     // zero-based index of the current pulse
    logic            r_mode8086;  // mode latched at the start edge
    logic            r_inta_n;
    logic            r_valid;
    logic            r_busy;
    logic [7:0]      r_vector;
    logic [15:0]     r_call;
`ifdef OPCODE_CHECK_EN
    logic            r_perr;
`endif

    logic            w_last_pulse;

    assign w_last_pulse = r_mode8086 ? (r_pulse == 2'd1) : (r_pulse == 2'd2);

    // Sequencer FSM with all outputs registered; byte capture happens on the edge
    // that ends each low pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cycle    <= '0;
            r_pulse    <= 2'd0;
            r_mode8086 <= 1'b0;
            r_inta_n   <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_vector   <= 8'h00;
            r_call     <= 16'h0000;
`ifdef OPCODE_CHECK_EN
            r_perr     <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.INT && bus.interruptEnable) begin
                        r_state    <= StPulseLow;
                        r_cycle    <= '0;
                        r_pulse    <= 2'd0;
                        r_mode8086 <= bus.mode8086;
                        r_inta_n   <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                StPulseLow: begin
                    if (r_cycle == LowLast) begin
                        r_inta_n <= 1'b1;
                        r_cycle  <= '0;
                        // 8086 discards the first byte; only the vector slot is written.
                        if (r_mode8086) begin
                            if (r_pulse == 2'd1) begin
                                r_vector <= bus.dataBus;
                            end
                        end else begin
                            if (r_pulse == 2'd1) begin
                                r_call[7:0] <= bus.dataBus;
                            end else if (r_pulse == 2'd2) begin
                                r_call[15:8] <= bus.dataBus;
                            end
                        end
`ifdef OPCODE_CHECK_EN
                        if (!r_mode8086 && (r_pulse == 2'd0) && (bus.dataBus != 8'hCD)) begin
                            r_perr <= 1'b1;
                        end
`endif
                        if (w_last_pulse) begin
                            r_state <= StPresent;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= StGap;
                            r_pulse <= r_pulse + 2'd1;
                        end
                    end else begin
                        r_cycle <= r_cycle + 1'b1;
                    end
                end

                StGap: begin
                    if (r_cycle == GapLast) begin
                        r_state  <= StPulseLow;
                        r_cycle  <= '0;
                        r_inta_n <= 1'b0;
                    end else begin
                        r_cycle <= r_cycle + 1'b1;
                    end
                end

                StPresent: begin
                    // INT is not looked at here, which guarantees an idle cycle before
                    // the next sequence.
                    if (bus.vectorAck) begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= StIdle;
                    r_inta_n <= 1'b1;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INTA_n      = r_inta_n;
    assign bus.vectorValid = r_valid;
    assign bus.vectorData  = r_vector;
    assign bus.callAddress = r_call;
    assign bus.busy        = r_busy;
`ifdef OPCODE_CHECK_EN
    assign bus.protocolError = r_perr;
`else
    assign bus.protocolError = 1'b0;
`endif

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

CPU-side counterpart of the PIC's interrupt request path: it watches the PIC's INT output, runs the INTA acknowledge pulse train, and captures the bytes the PIC drives onto the data bus. It supports 8086 mode (two INTA pulses, vector type on the second) and 8080/85 mode (three pulses: CALL opcode, low address, high address). The captured result goes to the core or testbench through a valid/ack handshake. It sits between the PIC's INT/INTA/data-buffer pins and the processor model in the PIC system bench.

## Interface
Parameters:
- INTA_LOW_CYCLES, 2, clock cycles INTA_n stays low per pulse (≥1)
- INTA_GAP_CYCLES, 1, clock cycles INTA_n stays high between pulses (≥1)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- INT  in  1  interrupt request from PIC, level, sampled on clk
- interruptEnable  in  1  CPU IF flag; gates the start of a sequence only
- mode8086  in  1  1 = two-pulse 8086 sequence, 0 = three-pulse 8080 sequence
- dataBus  in  8  PIC data buffer output
- vectorAck  in  1  consumer accepts the presented result
- INTA_n  out  1  interrupt acknowledge to PIC, active-low
- vectorValid  out  1  result held valid until acknowledged
- vectorData  out  8  8086 vector type byte
- callAddress  out  16  8080 CALL target {high, low}
- busy  out  1  high in any state other than IDLE
- protocolError  out  1  sticky opcode-check flag (see Configuration)

## Operation
- States: IDLE, PULSE_LOW, GAP, PRESENT. A pulse counter (0..2) and a cycle counter (width for max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)) drive the transitions.
- IDLE -> PULSE_LOW when INT=1 and interruptEnable=1 at an edge. mode8086 is latched at this edge and held for the rest of the sequence.
- PULSE_LOW: INTA_n=0 for INTA_LOW_CYCLES cycles. On the edge that deasserts INTA_n, dataBus is captured into the byte slot for the current pulse number.
  - If this was the last pulse (pulse 2 in 8086 mode, pulse 3 in 8080 mode), go to PRESENT. Otherwise go to GAP.
- GAP: INTA_n=1 for INTA_GAP_CYCLES cycles, then PULSE_LOW for the next pulse.
- Byte slots:
  - 8086: pulse 1 byte is discarded; pulse 2 byte goes to vectorData.
  - 8080: pulse 1 byte is the opcode; pulse 2 byte goes to callAddress[7:0]; pulse 3 byte goes to callAddress[15:8].
- PRESENT: vectorValid=1. Outputs stay stable until an edge with vectorAck=1, then return to IDLE with vectorValid=0.
- Once started, a sequence always runs to completion. INT falling, interruptEnable falling, or mode8086 changing mid-sequence are all ignored.
- vectorData and callAddress keep their last values in IDLE. The field not written in the current mode is left unchanged.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE, INTA_n=1, vectorValid=0, vectorData=8'h00, callAddress=16'h0000, busy=0, protocolError=0.
- Reset mid-sequence aborts the sequence. INTA_n is high from the cycle after the reset edge.
- All outputs are registered.
- With start edge N:
  - INTA_n falls after edge N.
  - Byte k is captured at edge N + k·INTA_LOW_CYCLES + (k−1)·INTA_GAP_CYCLES.
- vectorValid rises:
  - 8086: after edge N + 2·LOW + GAP (defaults: N+5).
  - 8080: after edge N + 3·LOW + 2·GAP (defaults: N+8).
- On the ack edge, INT is not sampled. The earliest next start is the following edge, so INTA_n is high for at least one cycle between sequences.
- vectorAck while vectorValid=0 is ignored.

## Configuration
- OPCODE_CHECK_EN defined: in 8080 mode, if the pulse 1 byte ≠ 8'hCD, protocolError is set. It stays set until reset. The sequence still completes and presents normally.
- OPCODE_CHECK_EN undefined: the opcode byte is not checked, and protocolError is tied to 0.

## Test plan
- 8086, defaults: hold INT=1, interruptEnable=1; drive dataBus=8'h48 during pulse 2 -> exactly two INTA_n low pulses of 2 cycles, 1-cycle gap; vectorValid after edge N+5; vectorData=8'h48.
- 8080, defaults: bytes 8'hCD, 8'h20, 8'h3F -> three pulses; callAddress=16'h3F20; vectorValid after edge N+8; protocolError=0.
- interruptEnable=0 with INT=1 for 10 cycles -> INTA_n stays 1, busy=0. Raise interruptEnable -> sequence starts on the next edge.
- Delay vectorAck 5 cycles with INT still high -> outputs stable for those 5 cycles. After the ack edge, INTA_n is high for ≥1 cycle, then a new sequence starts.
- rst_n=0 during pulse 2 of an 8080 sequence -> INTA_n=1 and all outputs at reset values the next cycle; no vectorValid.
- OPCODE_CHECK_EN defined, 8080, first byte 8'hC3 -> protocolError=1 after the pulse 1 capture edge, sequence still presents, flag persists across a later good sequence.
